// File: rtl/bp_me_stream_to_lite_buffered.sv
// Assembles BedRock stream beats into full-width lite messages and queues up to els_p
// completed messages. Header layout: msg_type [3:0], size [6:4] (log2 bytes), the rest is address.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  e_first | idle / expecting the first beat (header taken from this beat)
//  e_accum | collecting beats 1..N-1 of a multi-beat message
module bp_me_stream_to_lite_buffered #(
    parameter int          in_data_width_p  = 64,
    parameter int          out_data_width_p = 512,
    parameter int          els_p            = 2,
    parameter logic [15:0] payload_mask_p   = '0,
    parameter int          header_width_p   = 48,
    localparam int bp_bedrock_in_mem_msg_header_width_lp = header_width_p,
    localparam int bp_bedrock_out_mem_msg_width_lp       = header_width_p + out_data_width_p
) (
    input  logic                                             clk_i,
    input  logic                                             reset_i,
    input  logic [bp_bedrock_in_mem_msg_header_width_lp-1:0] mem_header_i,
    input  logic [in_data_width_p-1:0]                       mem_data_i,
    input  logic                                             mem_v_i,
    output logic                                             mem_ready_o,
    input  logic                                             mem_lock_i,
    output logic [bp_bedrock_out_mem_msg_width_lp-1:0]       mem_o,
    output logic                                             mem_v_o,
    input  logic                                             mem_ready_i,
    output logic                                             protocol_error_o
);

    localparam int words_lp    = out_data_width_p / in_data_width_p;
    localparam int cnt_w_lp    = (words_lp > 1) ? $clog2(words_lp) : 1;
    localparam int lg_words_lp = $clog2(words_lp);
    localparam int lg_bpb_lp   = $clog2(in_data_width_p / 8);
    localparam int ptr_w_lp    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int occ_w_lp    = $clog2(els_p + 1);

    if (out_data_width_p % in_data_width_p != 0) begin : g_bad_ratio
        $error("out_data_width_p must be a multiple of in_data_width_p");
    end
    if (in_data_width_p > out_data_width_p) begin : g_bad_width
        $error("in_data_width_p must not exceed out_data_width_p");
    end

    typedef enum logic {e_first, e_accum} state_e;

    state_e                                 state_r, state_n;
    logic [cnt_w_lp-1:0]                    cnt_r, cnt_n, last_r, last_n;
    logic [cnt_w_lp-1:0]                    last_hdr, beat_idx, beat_last;
    logic [header_width_p-1:0]              header_r, header_n, beat_header;
    logic [2:0]                             hdr_size;
    logic [words_lp-1:0][in_data_width_p-1:0] slot_r, slot_n;
    logic [out_data_width_p-1:0]            data_asm;
    logic                                   xfer, final_beat, push, pop, error_r;

    logic [bp_bedrock_out_mem_msg_width_lp-1:0] fifo_r [els_p];
    logic [ptr_w_lp-1:0]                        wptr_r, rptr_r;
    logic [occ_w_lp-1:0]                        occ_r;

    assign hdr_size = mem_header_i[6:4];

    // Beats minus one, derived from the first-beat header; clamped to the lite width.
    always_comb begin
        last_hdr = '0;
        if (payload_mask_p[mem_header_i[3:0]] && (int'(hdr_size) >= lg_bpb_lp)) begin
            if (int'(hdr_size) - lg_bpb_lp >= lg_words_lp)
                last_hdr = cnt_w_lp'(words_lp - 1);
            else
                last_hdr = cnt_w_lp'((1 << (int'(hdr_size) - lg_bpb_lp)) - 1);
        end
    end

    assign mem_ready_o = (occ_r < occ_w_lp'(els_p));
    assign xfer        = mem_v_i & mem_ready_o;
    assign beat_idx    = (state_r == e_first) ? '0 : cnt_r;
    assign beat_last   = (state_r == e_first) ? last_hdr : last_r;
    assign beat_header = (state_r == e_first) ? mem_header_i : header_r;
    assign final_beat  = (beat_idx == beat_last);
    assign push        = xfer & final_beat;
    assign mem_v_o     = (occ_r != '0);
    assign pop         = mem_v_o & mem_ready_i;
    assign mem_o       = fifo_r[rptr_r];
    assign protocol_error_o = error_r;

    // Beat counts are powers of two, so masking the word index replicates the payload.
    always_comb begin
        slot_n = slot_r;
        if (xfer)
            slot_n[beat_idx] = mem_data_i;
        data_asm = '0;
        for (int j = 0; j < words_lp; j++)
            data_asm[j*in_data_width_p +: in_data_width_p] = slot_n[cnt_w_lp'(j) & beat_last];
    end

    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        last_n   = last_r;
        header_n = header_r;
        if (xfer) begin
            case (state_r)
                e_first: begin
                    header_n = mem_header_i;
                    last_n   = last_hdr;
                    if (!final_beat) begin
                        cnt_n   = cnt_w_lp'(1);
                        state_n = e_accum;
                    end
                end
                e_accum: begin
                    if (final_beat) begin
                        cnt_n   = '0;
                        state_n = e_first;
                    end else begin
                        cnt_n = cnt_r + cnt_w_lp'(1);
                    end
                end
                default: state_n = e_first;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= e_first;
            cnt_r    <= '0;
            last_r   <= '0;
            header_r <= '0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_n;
            cnt_r    <= cnt_n;
            last_r   <= last_n;
            header_r <= header_n;
            if (xfer && (mem_lock_i == final_beat))
                error_r <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        slot_r <= slot_n;
        if (push)
            fifo_r[wptr_r] <= {beat_header, data_asm};
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            occ_r  <= '0;
        end else begin
            if (push)
                wptr_r <= (wptr_r == ptr_w_lp'(els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
            if (pop)
                rptr_r <= (rptr_r == ptr_w_lp'(els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
            occ_r <= occ_r + occ_w_lp'(push) - occ_w_lp'(pop);
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk_i) disable iff (reset_i) !(push && !mem_ready_o));
`endif

endmodule
